// File: rtl/bit_packer_fifo.sv
// Purpose: packs a serial bit stream MSB-first into WORD_W-bit words, each stored with its ones count in a DEPTH-entry FIFO.
// Latency: a word is visible at the FIFO head one edge after its last bit is accepted; the head drives the outputs directly.
// Backpressure: word_valid/word_ready handshake; a word completed while the FIFO is full with no pop is dropped and overflow is set.
module bit_packer_fifo #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    output logic [WORD_W-1:0]         word_out,
    output logic [$clog2(WORD_W):0]   ones_out,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    input  logic                      clr_ovf
);

    localparam int CW = $clog2(WORD_W);
    localparam int OW = CW + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Packer state: bit position, partial word and its running ones count.
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [WORD_W-1:0] shreg_q,  shreg_d;
    logic [OW-1:0]     ones_q,   ones_d;

    // FIFO bookkeeping.
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic              ovf_q,    ovf_d;

    // Storage is never reset; it is only observable through a non-empty head.
    logic [WORD_W-1:0] mem_word [DEPTH];
    logic [OW-1:0]     mem_ones [DEPTH];

    logic [WORD_W-1:0] word_full;
    logic [OW-1:0]     ones_full;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              drop;

    // Completed-word view and push/pop decisions for this edge.
    always_comb begin
        word_full = {shreg_q[WORD_W-2:0], bit_in};
        ones_full = ones_q + OW'(bit_in);
        push      = bit_valid && (cnt_q == CW'(WORD_W - 1));
        pop       = (level_q != '0) && word_ready;
        full      = (level_q == LW'(DEPTH));
        // A pop on the same edge frees the slot the push needs.
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;
    end

    // Next-state for packer, pointers, level and sticky overflow.
    always_comb begin
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        ones_d   = ones_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (bit_valid) begin
            if (push) begin
                cnt_d   = '0;
                shreg_d = '0;
                ones_d  = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                shreg_d = word_full;
                ones_d  = ones_full;
            end
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (wr_en && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !wr_en) begin
            level_d = level_q - LW'(1);
        end

        // Set beats clear when both happen on the same edge.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shreg_q  <= '0;
            ones_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            ones_q   <= ones_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage write; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_word[wr_ptr_q] <= word_full;
            mem_ones[wr_ptr_q] <= ones_full;
        end
    end

    assign word_out   = mem_word[rd_ptr_q];
    assign ones_out   = mem_ones[rd_ptr_q];
    assign word_valid = (level_q != '0);
    assign level      = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bit_packer_fifo.sv
// Purpose: self-checking bench for bit_packer_fifo against a queue-based reference model.
// Latency: every edge is followed #1 later by a full comparison of DUT outputs with the model.
// Backpressure: word_ready is driven by directed sequences and then randomly.
module tb_bit_packer_fifo;

    localparam int W = 8;
    localparam int D = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    bit_in;
    logic                    bit_valid;
    logic [W-1:0]            word_out;
    logic [$clog2(W):0]      ones_out;
    logic                    word_valid;
    logic                    word_ready;
    logic [$clog2(D):0]      level;
    logic                    overflow;
    logic                    clr_ovf;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: completed words waiting, bits of the word in progress, sticky flag.
    int unsigned mq[$];
    int          mbits[$];
    bit          movf = 1'b0;

    bit_packer_fifo #(.WORD_W(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .ones_out   (ones_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .level      (level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned popcnt(input int unsigned v);
        int unsigned c = 0;
        for (int i = 0; i < W; i++) c += (v >> i) & 1;
        return c;
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        bit          do_push = 1'b0;
        int unsigned w = 0;
        bit          do_pop;
        if (!rst_n) begin
            mq.delete();
            mbits.delete();
            movf = 1'b0;
            return;
        end
        do_pop = word_ready && (mq.size() > 0);
        if (bit_valid) begin
            mbits.push_back(int'(bit_in));
            if (mbits.size() == W) begin
                for (int i = 0; i < W; i++) w += mbits[i] << (W - 1 - i);
                mbits.delete();
                do_push = 1'b1;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (clr_ovf) movf = 1'b0;
        if (do_push) begin
            if (mq.size() < D) mq.push_back(w);
            else movf = 1'b1;
        end
    endtask

    // One clock edge: update model, then compare all outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("word_valid", word_valid, (mq.size() != 0));
        check_eq("level", level, mq.size());
        check_eq("overflow", overflow, movf);
        if (mq.size() != 0) begin
            check_eq("word_out", word_out, mq[0]);
            check_eq("ones_out", ones_out, popcnt(mq[0]));
        end
    endtask

    task automatic idle_inputs();
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        word_ready = 1'b0;
        clr_ovf    = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Send one word MSB-first on consecutive edges; ready/clr apply only on the last bit.
    task automatic send_word(input logic [W-1:0] w, input bit rdy_last, input bit clr_last);
        for (int i = W - 1; i >= 0; i--) begin
            bit_in     = w[i];
            bit_valid  = 1'b1;
            word_ready = (i == 0) ? rdy_last : 1'b0;
            clr_ovf    = (i == 0) ? clr_last : 1'b0;
            tick();
        end
        idle_inputs();
    endtask

    task automatic drain_expect(input logic [W-1:0] exp, input string tag);
        check_eq(tag, word_out, exp);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] pat;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_valid", word_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_ovf", overflow, 0);

        // Basic pack with no backpressure release.
        send_word(8'hB2, 1'b0, 1'b0);
        check_eq("b2_valid", word_valid, 1);
        check_eq("b2_word", word_out, 8'hB2);
        check_eq("b2_ones", ones_out, 4);
        check_eq("b2_level", level, 1);

        // Same word with a 3-cycle gap between bits 4 and 5.
        do_reset();
        pat = 8'hB2;
        for (int i = W - 1; i >= 0; i--) begin
            bit_in = pat[i];
            bit_valid = 1'b1;
            tick();
            if (i == 4) begin
                bit_valid = 1'b0;
                repeat (3) tick();
            end
            if (i == 1) check_eq("gap_not_yet", word_valid, 0);
        end
        idle_inputs();
        check_eq("gap_valid", word_valid, 1);
        check_eq("gap_word", word_out, 8'hB2);

        // Overflow: five words into a 4-deep FIFO, then drain.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            pat = 8'(k);
            send_word(pat, 1'b0, 1'b0);
        end
        check_eq("ovf_level", level, 4);
        check_eq("ovf_flag", overflow, 1);
        for (int k = 1; k <= 4; k++) drain_expect(8'(k), "ovf_drain");
        check_eq("ovf_empty", level, 0);
        check_eq("ovf_empty_vld", word_valid, 0);
        // Ready on an empty FIFO must not underflow.
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check_eq("no_underflow", level, 0);

        // Clear with no push.
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("clr_ovf", overflow, 0);

        // Full FIFO with simultaneous pop and push.
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b0);
        send_word(8'h44, 1'b0, 1'b0);
        send_word(8'hAA, 1'b1, 1'b0);
        check_eq("pp_ovf", overflow, 0);
        check_eq("pp_level", level, 4);
        drain_expect(8'h22, "pp_drain");
        drain_expect(8'h33, "pp_drain");
        drain_expect(8'h44, "pp_drain");
        drain_expect(8'hAA, "pp_last");
        check_eq("pp_empty", level, 0);

        // Clear coincident with a dropped push: set wins.
        for (int k = 0; k < 4; k++) send_word(8'h5A, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b1);
        check_eq("clr_vs_set", overflow, 1);

        // Reset discards a partial word.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bit_in = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        idle_inputs();
        do_reset();
        send_word(8'hFF, 1'b0, 1'b0);
        check_eq("rstp_level", level, 1);
        check_eq("rstp_word", word_out, 8'hFF);
        check_eq("rstp_ones", ones_out, 8);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit_valid  = ($urandom_range(0, 9) < 7);
            bit_in     = 1'($urandom);
            word_ready = ($urandom_range(0, 9) < 3);
            clr_ovf    = ($urandom_range(0, 19) == 0);
            rst_n      = ($urandom_range(0, 199) != 0);
            tick();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
